// File: rtl/write_logic_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// write_logic_ctrl_pkg
// Shared definitions for the FIFO write-side controller:
//   - default geometry (MEM_SIZE, WORD_SIZE, PTR)
//   - occupancy state encodings
//   - helper that decides whether a write request must be dropped
// -----------------------------------------------------------------------------
package write_logic_ctrl_pkg;

  localparam int DEF_MEM_SIZE  = 8;
  localparam int DEF_WORD_SIZE = 10;
  localparam int DEF_PTR       = 3;

  typedef enum logic [1:0] {
    ST_EMPTY  = 2'd0,
    ST_NORMAL = 2'd1,
    ST_ALMOST = 2'd2,
    ST_FULL   = 2'd3
  } state_t;

  // A write is dropped only when the FIFO is full and the reader does not
  // free a slot in the same cycle.
  function automatic logic write_dropped(input logic wr, input logic full, input logic rd);
    return wr & full & ~rd;
  endfunction

endpackage

// File: rtl/fifo_occupancy.sv
// -----------------------------------------------------------------------------
// fifo_occupancy
// Occupancy counter for the FIFO: tracks accepted pushes against pops.
//   clk        in   clock, rising edge
//   reset      in   synchronous, active-low reset (clears count)
//   push       in   accepted write this cycle
//   pop        in   read strobe this cycle
//   count      out  current occupancy (PTR+1 bits)
//   count_next out  occupancy after this cycle's push/pop
// Count never underflows below 0 nor climbs above MEM_SIZE.
// -----------------------------------------------------------------------------
module fifo_occupancy
  import write_logic_ctrl_pkg::*;
#(
  parameter int MEM_SIZE = DEF_MEM_SIZE,
  parameter int PTR      = DEF_PTR
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  output logic [PTR:0] count,
  output logic [PTR:0] count_next
);

  localparam logic [PTR:0] MEM_SIZE_C = (PTR+1)'(MEM_SIZE);
  localparam logic [PTR:0] ONE_C      = (PTR+1)'(1);

  // Up/down/hold decision; a simultaneous push and pop leaves count unchanged.
  always_comb begin
    count_next = count;
    if (push && !pop && (count != MEM_SIZE_C)) begin
      count_next = count + ONE_C;
    end else if (pop && !push && (count != '0)) begin
      count_next = count - ONE_C;
    end else begin
      count_next = count;
    end
  end

  // Occupancy register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= '0;
    end else begin
      count <= count_next;
    end
  end

endmodule

// File: rtl/write_logic_ctrl.sv
// -----------------------------------------------------------------------------
// write_logic_ctrl
// Write-side FIFO controller: accepts write requests, drives the memory write
// strobe and address, tracks occupancy against the read side's pop and
// produces the status flags shared by both ends.
//
// Ports:
//   clk           in   clock, rising edge
//   reset         in   synchronous, active-low reset
//   fifo_wr       in   producer write request
//   pop           in   read strobe from the read-side controller (same cycle)
//   umbral_alto   in   almost-full threshold  (PTR+1 bits)
//   umbral_bajo   in   almost-empty threshold (PTR+1 bits)
//   push          out  memory write enable (combinational)
//   wr_ptr        out  write address (PTR bits)
//   fifo_full     out  occupancy == MEM_SIZE (registered)
//   fifo_empty    out  occupancy == 0 (registered)
//   almost_full   out  occupancy >= umbral_alto (registered)
//   almost_empty  out  occupancy <= umbral_bajo (registered)
//   error         out  sticky overflow flag, cleared only by reset
//   ovf_count     out  [7:0] saturating dropped-write counter
//                      (only when WRITE_OVF_COUNT_EN is defined)
//
// Build option: define WRITE_OVF_COUNT_EN to add the ovf_count output.
// -----------------------------------------------------------------------------
module write_logic_ctrl
  import write_logic_ctrl_pkg::*;
#(
  parameter int MEM_SIZE  = DEF_MEM_SIZE,
  parameter int WORD_SIZE = DEF_WORD_SIZE,
  parameter int PTR       = DEF_PTR
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           fifo_wr,
  input  logic           pop,
  input  logic [PTR:0]   umbral_alto,
  input  logic [PTR:0]   umbral_bajo,
  output logic           push,
  output logic [PTR-1:0] wr_ptr,
  output logic           fifo_full,
  output logic           fifo_empty,
  output logic           almost_full,
  output logic           almost_empty,
  output logic           error
`ifdef WRITE_OVF_COUNT_EN
  ,
  output logic [7:0]     ovf_count
`else
`endif
);

  localparam logic [PTR:0]   MEM_SIZE_C = (PTR+1)'(MEM_SIZE);
  localparam logic [PTR-1:0] PTR_LAST_C = PTR'(MEM_SIZE - 1);
  localparam logic [PTR-1:0] PTR_ONE_C  = PTR'(1);

  // WORD_SIZE only travels with the memory; it is checked here so a bad
  // configuration is caught at elaboration time.
  if ((MEM_SIZE > (1 << PTR)) || (MEM_SIZE < 1) || (WORD_SIZE < 1)) begin : g_cfg_err
    $error("write_logic_ctrl: invalid MEM_SIZE/PTR/WORD_SIZE combination");
  end

  logic [PTR:0]   count_s;
  logic [PTR:0]   count_next_s;
  logic           drop_s;
  state_t         state_r;
  state_t         state_next_s;
  logic [PTR-1:0] wr_ptr_r;
  logic           almost_full_r;
  logic           almost_empty_r;
  logic           error_r;

  // Write acceptance: while full, a write goes through only alongside a pop.
  always_comb begin
    push   = reset & fifo_wr & (~fifo_full | pop);
    drop_s = reset & write_dropped(fifo_wr, fifo_full, pop);
  end

  fifo_occupancy #(
    .MEM_SIZE (MEM_SIZE),
    .PTR      (PTR)
  ) u_occupancy (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .pop        (pop),
    .count      (count_s),
    .count_next (count_next_s)
  );

  // Next state is decoded from the next count so flags land one cycle after
  // the push/pop that causes them; any state can reach any other directly.
  always_comb begin
    state_next_s = state_r;
    if (count_next_s == '0) begin
      state_next_s = ST_EMPTY;
    end else if (count_next_s == MEM_SIZE_C) begin
      state_next_s = ST_FULL;
    end else if (count_next_s >= umbral_alto) begin
      state_next_s = ST_ALMOST;
    end else begin
      state_next_s = ST_NORMAL;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r <= ST_EMPTY;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Write pointer advances on every accepted push and wraps at MEM_SIZE-1.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_r <= '0;
    end else if (push) begin
      wr_ptr_r <= (wr_ptr_r == PTR_LAST_C) ? '0 : (wr_ptr_r + PTR_ONE_C);
    end else begin
      wr_ptr_r <= wr_ptr_r;
    end
  end

  // Threshold flags compare the next count against this cycle's thresholds.
  always_ff @(posedge clk) begin
    if (!reset) begin
      almost_full_r  <= 1'b0;
      almost_empty_r <= 1'b1;
    end else begin
      almost_full_r  <= (count_next_s >= umbral_alto);
      almost_empty_r <= (count_next_s <= umbral_bajo);
    end
  end

  // Sticky overflow flag.
  always_ff @(posedge clk) begin
    if (!reset) begin
      error_r <= 1'b0;
    end else if (drop_s) begin
      error_r <= 1'b1;
    end else begin
      error_r <= error_r;
    end
  end

`ifdef WRITE_OVF_COUNT_EN
  logic [7:0] ovf_count_r;

  // Dropped-write counter, saturating at 255.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ovf_count_r <= 8'd0;
    end else if (drop_s && (ovf_count_r != 8'hFF)) begin
      ovf_count_r <= ovf_count_r + 8'd1;
    end else begin
      ovf_count_r <= ovf_count_r;
    end
  end

  assign ovf_count = ovf_count_r;
`else
`endif

  assign wr_ptr       = wr_ptr_r;
  assign fifo_full    = (state_r == ST_FULL);
  assign fifo_empty   = (state_r == ST_EMPTY);
  assign almost_full  = almost_full_r;
  assign almost_empty = almost_empty_r;
  assign error        = error_r;

endmodule

// File: tb/tb_write_logic_ctrl.sv
// -----------------------------------------------------------------------------
// tb_write_logic_ctrl
// Directed self-checking bench for write_logic_ctrl (MEM_SIZE=8, PTR=3).
// Inputs change 1 time unit after the rising edge; registered outputs are
// checked there, push is checked 1 unit after the inputs settle.
// -----------------------------------------------------------------------------
module tb_write_logic_ctrl;

  logic       clk;
  logic       reset;
  logic       fifo_wr;
  logic       pop;
  logic [3:0] umbral_alto;
  logic [3:0] umbral_bajo;
  logic       push;
  logic [2:0] wr_ptr;
  logic       fifo_full;
  logic       fifo_empty;
  logic       almost_full;
  logic       almost_empty;
  logic       error;
`ifdef WRITE_OVF_COUNT_EN
  logic [7:0] ovf_count;
`endif

  int checks;
  int errors;

  write_logic_ctrl #(
    .MEM_SIZE  (8),
    .WORD_SIZE (10),
    .PTR       (3)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .fifo_wr      (fifo_wr),
    .pop          (pop),
    .umbral_alto  (umbral_alto),
    .umbral_bajo  (umbral_bajo),
    .push         (push),
    .wr_ptr       (wr_ptr),
    .fifo_full    (fifo_full),
    .fifo_empty   (fifo_empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .error        (error)
`ifdef WRITE_OVF_COUNT_EN
    ,
    .ovf_count    (ovf_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just past the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle synchronous reset, then release with idle inputs.
  task automatic do_reset();
    reset   = 1'b0;
    fifo_wr = 1'b0;
    pop     = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  // Apply inputs, check push combinationally, then clock.
  task automatic cycle(input logic wr, input logic rd, input logic exp_push, input string tag);
    fifo_wr = wr;
    pop     = rd;
    #1;
    chk(tag, {31'd0, push}, {31'd0, exp_push});
    tick();
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    reset       = 1'b0;
    fifo_wr     = 1'b0;
    pop         = 1'b0;
    umbral_alto = 4'd6;
    umbral_bajo = 4'd1;

    // Reset held two cycles, with a write request during the second.
    tick();
    fifo_wr = 1'b1;
    #1;
    chk("rst_push", {31'd0, push}, 32'd0);
    tick();
    chk("rst_wr_ptr", {29'd0, wr_ptr}, 32'd0);
    chk("rst_empty", {31'd0, fifo_empty}, 32'd1);
    chk("rst_full", {31'd0, fifo_full}, 32'd0);
    chk("rst_error", {31'd0, error}, 32'd0);
    chk("rst_aempty", {31'd0, almost_empty}, 32'd1);
    chk("rst_afull", {31'd0, almost_full}, 32'd0);
    fifo_wr = 1'b0;
    reset   = 1'b1;

    // Eight writes, no pop, umbral_alto=6: flags track count=i before push i.
    for (int i = 0; i < 8; i++) begin
      chk("fill_wr_ptr", {29'd0, wr_ptr}, i);
      chk("fill_afull", {31'd0, almost_full}, (i >= 6) ? 32'd1 : 32'd0);
      chk("fill_aempty", {31'd0, almost_empty}, (i <= 1) ? 32'd1 : 32'd0);
      chk("fill_empty", {31'd0, fifo_empty}, (i == 0) ? 32'd1 : 32'd0);
      chk("fill_full", {31'd0, fifo_full}, 32'd0);
      cycle(1'b1, 1'b0, 1'b1, "fill_push");
    end
    chk("fill_full_end", {31'd0, fifo_full}, 32'd1);
    chk("fill_wrap_ptr", {29'd0, wr_ptr}, 32'd0);
    chk("fill_afull_end", {31'd0, almost_full}, 32'd1);

    // Write while full, no pop: dropped, error sticks.
    cycle(1'b1, 1'b0, 1'b0, "ovf_push");
    chk("ovf_wr_ptr", {29'd0, wr_ptr}, 32'd0);
    chk("ovf_error", {31'd0, error}, 32'd1);
    chk("ovf_full", {31'd0, fifo_full}, 32'd1);
`ifdef WRITE_OVF_COUNT_EN
    chk("ovf_count", {24'd0, ovf_count}, 32'd1);
`endif
    cycle(1'b0, 1'b0, 1'b0, "ovf_idle_push");
    chk("ovf_error_sticky", {31'd0, error}, 32'd1);

    // Refill, then write+pop while full.
    do_reset();
    chk("rst2_error", {31'd0, error}, 32'd0);
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 1'b1, "refill_push");
    chk("refill_full", {31'd0, fifo_full}, 32'd1);
    cycle(1'b1, 1'b1, 1'b1, "fullrw_push");
    chk("fullrw_wr_ptr", {29'd0, wr_ptr}, 32'd1);
    chk("fullrw_full", {31'd0, fifo_full}, 32'd1);
    chk("fullrw_error", {31'd0, error}, 32'd0);

    // Empty FIFO: write+pop keeps count 0; pop alone does not underflow.
    do_reset();
    cycle(1'b1, 1'b1, 1'b1, "emptyrw_push");
    chk("emptyrw_empty", {31'd0, fifo_empty}, 32'd1);
    chk("emptyrw_wr_ptr", {29'd0, wr_ptr}, 32'd1);
    cycle(1'b0, 1'b1, 1'b0, "emptypop_push");
    chk("emptypop_empty", {31'd0, fifo_empty}, 32'd1);
    chk("emptypop_aempty", {31'd0, almost_empty}, 32'd1);
    cycle(1'b1, 1'b0, 1'b1, "after_pop_push1");
    chk("count1_empty", {31'd0, fifo_empty}, 32'd0);
    chk("count1_aempty", {31'd0, almost_empty}, 32'd1);
    cycle(1'b1, 1'b0, 1'b1, "after_pop_push2");
    chk("count2_aempty", {31'd0, almost_empty}, 32'd0);
    chk("count2_wr_ptr", {29'd0, wr_ptr}, 32'd3);

    // Four writes then reset with a write request pending.
    do_reset();
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b1, "four_push");
    chk("four_wr_ptr", {29'd0, wr_ptr}, 32'd4);
    reset   = 1'b0;
    fifo_wr = 1'b1;
    #1;
    chk("midrst_push", {31'd0, push}, 32'd0);
    tick();
    chk("midrst_wr_ptr", {29'd0, wr_ptr}, 32'd0);
    chk("midrst_empty", {31'd0, fifo_empty}, 32'd1);
    chk("midrst_error", {31'd0, error}, 32'd0);
    reset   = 1'b1;
    fifo_wr = 1'b0;

    // Threshold edge cases: umbral_alto=0 forces almost_full,
    // umbral_bajo >= MEM_SIZE forces almost_empty.
    umbral_alto = 4'd0;
    umbral_bajo = 4'd8;
    cycle(1'b1, 1'b0, 1'b1, "thr_push1");
    chk("thr_afull0", {31'd0, almost_full}, 32'd1);
    chk("thr_aempty_hi", {31'd0, almost_empty}, 32'd1);
    for (int i = 0; i < 7; i++) cycle(1'b1, 1'b0, 1'b1, "thr_push");
    chk("thr_full", {31'd0, fifo_full}, 32'd1);
    chk("thr_aempty_full", {31'd0, almost_empty}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
